// File: rtl/msrv_32_store_buffer.sv
// msrv_32 store buffer: formats stores into a DEPTH-entry FIFO and drains it onto AHB-lite.
// Optional define MSRV32_STORE_MISALIGN_CHECK_EN rejects misaligned half/word stores.
module msrv_32_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    input  logic                   st_valid_in,
    output logic                   st_ready_out,
    input  logic [1:0]             funct3_in,
    input  logic [ADDR_W-1:0]      iaddr_in,
    input  logic [31:0]            rs2_in,
    output logic                   st_err_out,
    input  logic [ADDR_W-1:0]      ld_addr_in,
    output logic                   ld_conflict_out,
    output logic [ADDR_W-1:0]      ahb_haddr_out,
    output logic [1:0]             ahb_htrans_out,
    output logic                   ahb_hwrite_out,
    output logic [2:0]             ahb_hsize_out,
    output logic [31:0]            ahb_hwdata_out,
    output logic [3:0]             ahb_wr_mask_out,
    input  logic                   ahb_ready_in,
    output logic                   empty_out,
    output logic [$clog2(DEPTH):0] count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    logic          clk;
    logic          rst_n;
    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] cnt_nxt;
    logic          full_q;
    logic          err_q;

    logic [ADDR_W-3:0] q_addr [DEPTH];
    logic [31:0]       q_data [DEPTH];
    logic [3:0]        q_mask [DEPTH];
    logic [1:0]        q_size [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [DEPTH-1:0]  vld_nxt;

    logic [31:0] fmt_data;
    logic [3:0]  fmt_mask;
    logic        illegal;
    logic        misalign;
    logic        reject;
    logic        push;
    logic        pop;
    logic        unused_ld_bits;

    assign clk   = ms_riscv32_mp_clk_in;
    assign rst_n = ms_riscv32_mp_rst_in;

    always_comb begin
        fmt_data = '0;
        fmt_mask = '0;
        illegal  = 1'b0;
        unique case (funct3_in)
            2'b00: begin
                fmt_data = {24'b0, rs2_in[7:0]} << {iaddr_in[1:0], 3'b000};
                fmt_mask = 4'b0001 << iaddr_in[1:0];
            end
            2'b01: begin
                fmt_data = {16'b0, rs2_in[15:0]} << {iaddr_in[1], 4'b0000};
                fmt_mask = iaddr_in[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                fmt_data = rs2_in;
                fmt_mask = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef MSRV32_STORE_MISALIGN_CHECK_EN
    assign misalign = ((funct3_in == 2'b01) && iaddr_in[0]) ||
                      ((funct3_in == 2'b10) && (iaddr_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject  = illegal | misalign;
    assign push    = st_valid_in & st_ready_out & ~reject;
    assign pop     = (state == S_DATA) & ahb_ready_in;
    assign cnt_nxt = count_q + CW'(push) - CW'(pop);

    always_comb begin
        vld_nxt = q_vld;
        if (pop)
            vld_nxt[rd_ptr] = 1'b0;
        if (push)
            vld_nxt[wr_ptr] = 1'b1;
    end

    // Payload storage needs no reset; validity is tracked by q_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= iaddr_in[ADDR_W-1:2];
            q_data[wr_ptr] <= fmt_data;
            q_mask[wr_ptr] <= fmt_mask;
            q_size[wr_ptr] <= funct3_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            q_vld   <= '0;
        end else begin
            err_q   <= st_valid_in & reject;
            count_q <= cnt_nxt;
            full_q  <= (cnt_nxt == CW'(DEPTH));
            q_vld   <= vld_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case (state)
                S_IDLE: if (count_q != '0 || push) state <= S_ADDR;
                S_ADDR: if (ahb_ready_in) state <= S_DATA;
                S_DATA: if (ahb_ready_in)
                    state <= (cnt_nxt != '0) ? S_ADDR : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ld_conflict_out = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && q_addr[i] == ld_addr_in[ADDR_W-1:2])
                ld_conflict_out = 1'b1;
    end

    assign unused_ld_bits  = ^ld_addr_in[1:0];
    assign st_ready_out    = ~full_q;
    assign st_err_out      = err_q;
    assign count_out       = count_q;
    assign empty_out       = (count_q == '0) && (state == S_IDLE);
    assign ahb_htrans_out  = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign ahb_hwrite_out  = (state == S_ADDR);
    assign ahb_haddr_out   = (state == S_ADDR) ? {q_addr[rd_ptr], 2'b00} : '0;
    assign ahb_hsize_out   = (state == S_ADDR) ? {1'b0, q_size[rd_ptr]} : 3'b000;
    assign ahb_hwdata_out  = (state == S_DATA) ? q_data[rd_ptr] : 32'h0;
    assign ahb_wr_mask_out = (state == S_DATA) ? q_mask[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_msrv_32_store_buffer.sv
// Bench for msrv_32_store_buffer: vector table plus bus scoreboard and corner sequences.
// Expectations for misaligned stores follow MSRV32_STORE_MISALIGN_CHECK_EN.
module tb_msrv_32_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [1:0]    funct3 = '0;
    logic [31:0]   iaddr  = '0;
    logic [31:0]   rs2    = '0;
    logic          st_err;
    logic [31:0]   ld_addr = '0;
    logic          ld_conflict;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic [3:0]    wmask;
    logic          hready = 1'b1;
    logic          empty;
    logic [CW-1:0] count;

    msrv_32_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst_n),
        .st_valid_in(st_valid),
        .st_ready_out(st_ready),
        .funct3_in(funct3),
        .iaddr_in(iaddr),
        .rs2_in(rs2),
        .st_err_out(st_err),
        .ld_addr_in(ld_addr),
        .ld_conflict_out(ld_conflict),
        .ahb_haddr_out(haddr),
        .ahb_htrans_out(htrans),
        .ahb_hwrite_out(hwrite),
        .ahb_hsize_out(hsize),
        .ahb_hwdata_out(hwdata),
        .ahb_wr_mask_out(wmask),
        .ahb_ready_in(hready),
        .empty_out(empty),
        .count_out(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_t;

    typedef struct {
        logic [1:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        err;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] data;
        logic [3:0]  mask;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;
    bit   in_data = 0;
    int   addr_run = 0;
    int   last_run = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!empty && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        funct3   = f;
        iaddr    = a;
        rs2      = d;
        st_valid = 1'b1;
    endtask

    // Bus monitor: checks every address and data phase against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_data  = 0;
            addr_run = 0;
        end else if (in_data) begin
            chk("data_htrans", 32'(htrans), 32'd0);
            if (sb.size() == 0) begin
                chk("data_unexpected", 32'd1, 32'd0);
            end else begin
                chk("hwdata", hwdata, sb[0].data);
                chk("mask", 32'(wmask), 32'(sb[0].mask));
            end
            if (hready) begin
                if (sb.size() != 0)
                    void'(sb.pop_front());
                in_data = 0;
            end
        end else if (htrans == 2'b10) begin
            addr_run++;
            if (sb.size() == 0) begin
                chk("bus_unexpected", 32'(haddr), 32'hFFFF_FFFF);
            end else begin
                chk("haddr", haddr, sb[0].addr);
                chk("hsize", 32'(hsize), 32'(sb[0].size));
                chk("hwrite", 32'(hwrite), 32'd1);
            end
            if (hready) begin
                in_data  = 1;
                last_run = addr_run;
                addr_run = 0;
            end
        end else begin
            chk("idle_bus", {hwdata[27:0], wmask}, 32'd0);
            chk("idle_hwrite", 32'(hwrite), 32'd0);
        end
    end

    initial begin
        vecs[0] = '{2'd0, 32'h103, 32'hAABBCCDD, 1'b0, 32'h100, 3'd0, 32'hDD000000, 4'b1000};
        vecs[1] = '{2'd0, 32'h100, 32'h11223344, 1'b0, 32'h100, 3'd0, 32'h00000044, 4'b0001};
        vecs[2] = '{2'd0, 32'h101, 32'h00000055, 1'b0, 32'h100, 3'd0, 32'h00005500, 4'b0010};
        vecs[3] = '{2'd0, 32'h102, 32'h00000077, 1'b0, 32'h100, 3'd0, 32'h00770000, 4'b0100};
        vecs[4] = '{2'd1, 32'h202, 32'hFFFF1234, 1'b0, 32'h200, 3'd1, 32'h12340000, 4'b1100};
        vecs[5] = '{2'd1, 32'h200, 32'hABCD5678, 1'b0, 32'h200, 3'd1, 32'h00005678, 4'b0011};
        vecs[6] = '{2'd2, 32'h300, 32'hDEADBEEF, 1'b0, 32'h300, 3'd2, 32'hDEADBEEF, 4'b1111};
`ifdef MSRV32_STORE_MISALIGN_CHECK_EN
        vecs[7] = '{2'd2, 32'h301, 32'hCAFEF00D, 1'b1, 32'h0, 3'd0, 32'h0, 4'b0000};
        vecs[8] = '{2'd1, 32'h203, 32'h00009ABC, 1'b1, 32'h0, 3'd0, 32'h0, 4'b0000};
`else
        vecs[7] = '{2'd2, 32'h301, 32'hCAFEF00D, 1'b0, 32'h300, 3'd2, 32'hCAFEF00D, 4'b1111};
        vecs[8] = '{2'd1, 32'h203, 32'h00009ABC, 1'b0, 32'h200, 3'd1, 32'h9ABC0000, 4'b1100};
`endif
        vecs[9] = '{2'd3, 32'h500, 32'h12345678, 1'b1, 32'h0, 3'd0, 32'h0, 4'b0000};

        #2 rst_n = 1'b0;
        #2;
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_err", 32'(st_err), 32'd0);
        chk("rst_conflict", 32'(ld_conflict), 32'd0);
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_mask", 32'(wmask), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].f3, vecs[i].addr, vecs[i].rs2);
            if (!vecs[i].err)
                sb.push_back('{vecs[i].haddr, vecs[i].hsize, vecs[i].data, vecs[i].mask});
            @(posedge clk); #1;
            st_valid = 1'b0;
            chk($sformatf("v%0d_err", i), 32'(st_err), 32'(vecs[i].err));
            @(posedge clk); #1;
            chk($sformatf("v%0d_err_pulse", i), 32'(st_err), 32'd0);
            drain(20);
            chk($sformatf("v%0d_count", i), 32'(count), 32'd0);
        end

        // Address phase held by wait states
        @(posedge clk); #1;
        hready = 1'b0;
        drive(2'd1, 32'h202, 32'h00001234);
        sb.push_back('{32'h200, 3'd1, 32'h12340000, 4'b1100});
        @(posedge clk); #1;
        st_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        hready = 1'b1;
        drain(20);
        chk("hold_cycles", 32'(last_run), 32'd4);

        // Fill to DEPTH with the bus stalled, one extra request refused
        @(posedge clk); #1;
        hready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            drive(2'd2, 32'h600 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            if (i < DEPTH)
                sb.push_back('{32'h600 + 32'(4 * i), 3'd2, 32'h1000_0000 + 32'(i), 4'b1111});
            @(posedge clk); #1;
            chk($sformatf("full_ready_%0d", i), 32'(st_ready), 32'((i + 1) < DEPTH));
            chk($sformatf("full_count_%0d", i), 32'(count),
                32'((i + 1) < DEPTH ? i + 1 : DEPTH));
        end
        st_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_hold_count", 32'(count), 32'(DEPTH));
        hready = 1'b1;
        drain(40);
        chk("full_end_count", 32'(count), 32'd0);
        chk("full_end_ready", 32'(st_ready), 32'd1);

        // Load conflict against pending and in-flight entries
        @(posedge clk); #1;
        hready = 1'b0;
        drive(2'd2, 32'h404, 32'h0000_0044);
        sb.push_back('{32'h404, 3'd2, 32'h0000_0044, 4'b1111});
        @(posedge clk); #1;
        st_valid = 1'b0;
        ld_addr = 32'h407; #1;
        chk("conf_407", 32'(ld_conflict), 32'd1);
        ld_addr = 32'h408; #1;
        chk("conf_408", 32'(ld_conflict), 32'd0);
        ld_addr = 32'h403; #1;
        chk("conf_403", 32'(ld_conflict), 32'd0);
        ld_addr = 32'h407;
        hready  = 1'b1;
        @(posedge clk); #1;
        hready = 1'b0;
        chk("conf_inflight", 32'(ld_conflict), 32'd1);
        @(posedge clk); #1;
        hready = 1'b1;
        drain(10);
        #1;
        chk("conf_after_pop", 32'(ld_conflict), 32'd0);

        // Reset during a data phase with two entries queued
        @(posedge clk); #1;
        hready = 1'b0;
        drive(2'd2, 32'h700, 32'h7000_0000);
        sb.push_back('{32'h700, 3'd2, 32'h7000_0000, 4'b1111});
        @(posedge clk); #1;
        drive(2'd2, 32'h704, 32'h7000_0004);
        sb.push_back('{32'h704, 3'd2, 32'h7000_0004, 4'b1111});
        @(posedge clk); #1;
        st_valid = 1'b0;
        hready   = 1'b1;
        @(posedge clk); #1;
        hready = 1'b0;
        chk("rstmid_count_pre", 32'(count), 32'd2);
        ld_addr = 32'h704;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_htrans", 32'(htrans), 32'd0);
        chk("rstmid_mask", 32'(wmask), 32'd0);
        chk("rstmid_hwdata", hwdata, 32'd0);
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_empty", 32'(empty), 32'd1);
        chk("rstmid_conflict", 32'(ld_conflict), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        hready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("post_rst_htrans", 32'(htrans), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msrv_32_store_buffer.md
# msrv_32_store_buffer

Parametrised, buffered successor to the combinational store unit in the msrv_32 core. It accepts store requests from the write-back/memory stage, formats them into lane-aligned data and byte masks, and holds them in a DEPTH-entry FIFO. It drains the FIFO onto the AHB-lite data port with a proper address-phase/data-phase handshake, so the core does not stall on bus wait states. It also flags loads that hit a pending store word.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 32, address width; data width fixed at 32

Ports:
- ms_riscv32_mp_clk_in  in  1  core clock; all state changes on rising edge
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-low reset
- st_valid_in  in  1  store request valid
- st_ready_out  out  1  buffer can accept (= !full)
- funct3_in  in  2  00 byte, 01 half, 10 word, 11 illegal
- iaddr_in  in  ADDR_W  byte address
- rs2_in  in  32  store data, LSB-justified
- st_err_out  out  1  one-cycle pulse: request rejected
- ld_addr_in  in  ADDR_W  load byte address from execute stage
- ld_conflict_out  out  1  combinational: pending entry has same word address
- ahb_haddr_out  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- ahb_htrans_out  out  2  00 IDLE, 10 NONSEQ
- ahb_hwrite_out  out  1  1 during NONSEQ, else 0
- ahb_hsize_out  out  3  000/001/010 per entry size
- ahb_hwdata_out  out  32  lane-placed data, data phase only
- ahb_wr_mask_out  out  4  byte strobes, data phase only
- ahb_ready_in  in  1  HREADY
- empty_out  out  1  no entries and FSM IDLE
- count_out  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Accept: push on st_valid_in & st_ready_out & legal. An entry stores the word address, the formatted data, the mask and hsize.
- Formatting: for a byte store, rs2[7:0] goes to lane addr[1:0] and the mask is one-hot at that lane. For a half store, rs2[15:0] goes to lanes {addr[1],1}:{addr[1],0} and the mask is 0011 or 1100. For a word store, the data is rs2 and the mask is 1111. Unused lanes are 0.
- Reject: when funct3=11, the request is dropped and st_err_out pulses for one cycle. With the misalignment check enabled (see Configuration), misaligned requests are also dropped with a pulse.
- Drain FSM, states IDLE, ADDR, DATA:
  - IDLE→ADDR when the FIFO is non-empty.
  - In ADDR, htrans=10 and haddr/hsize come from the head entry. ADDR→DATA when ahb_ready_in=1; otherwise the state holds with the outputs stable.
  - In DATA, hwdata and mask come from the head entry and htrans=00. When ahb_ready_in=1, the head pops. The FSM then goes to ADDR if entries remain after the pop, otherwise to IDLE.
- No address/data overlap: at most one store is in flight; peak throughput is one store per 2 cycles.
- Outside DATA, hwdata and mask are 0.
- Full: st_ready_out=0 when count=DEPTH, even in a popping cycle. The full indication is registered from count.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count uses an extra bit so that full and empty are distinguishable.
- ld_conflict_out compares ld_addr_in[ADDR_W-1:2] against every valid entry, including the in-flight head.

## Timing
- Reset (asynchronous assert, synchronous release):
  - st_ready_out=1, st_err_out=0, ld_conflict_out=0.
  - htrans=00, hwrite=0, haddr=0, hsize=0, hwdata=0, mask=0.
  - count=0, empty=1, FSM=IDLE.
- Reset mid-transfer discards all entries immediately; the bus sees IDLE in the same cycle.
- Latency from an accepted push into an empty buffer:
  - next cycle: ADDR phase;
  - following cycle: DATA phase, if ready;
  - pop at the end of DATA.
- st_err_out is asserted in the cycle after the rejected request.
- Wait states hold every bus output stable until ahb_ready_in=1.

## Configuration
- MSRV32_STORE_MISALIGN_CHECK_EN:
  - Defined: a half store with addr[0]=1, or a word store with addr[1:0]≠00, is rejected with an st_err_out pulse.
  - Undefined: the low address bits are ignored for alignment. Half stores use addr[1] only; word stores always use the full word. Such requests are accepted without an error.

## Test plan
- Byte store, addr 0x103, rs2 0xAABBCCDD → ADDR phase haddr 0x100, hsize 000; DATA phase hwdata 0xDD000000, mask 1000; then empty=1.
- Half store, addr 0x202, rs2 0x1234 with ahb_ready_in low for 3 cycles in ADDR → htrans=10 and haddr=0x200 held stable for 4 cycles; DATA phase hwdata 0x12340000, mask 1100.
- DEPTH+1 back-to-back word stores with ready held low → st_ready_out=0 after DEPTH accepts and the last request is not accepted. After ready goes high, the entries drain in order, count reaches 0 and empty=1.
- Word store at 0x301 → with macro defined: st_err_out pulses, count unchanged, and no bus activity. With macro undefined: the store is accepted, haddr 0x300, mask 1111.
- Pending store to 0x404, ld_addr_in 0x407 → ld_conflict_out=1; with ld_addr_in 0x408 → 0; after the pop, 0x407 → 0.
- Reset asserted during a DATA phase with 2 entries queued → htrans=00, mask=0, count=0 immediately. After release there is no bus activity until a new push.
